// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and defaults for the CPU run controller and its benches.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } run_state_e;

  // OWN_CPU_RO lets the CPU address memory after a run without being able to write it.
  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_LOADER = 2'd1,
    OWN_CPU    = 2'd2,
    OWN_CPU_RO = 2'd3
  } dmem_owner_e;

  localparam logic [31:0] HALT_PC_DEF    = 32'h0000_0038;
  localparam int          MAX_CYCLES_DEF = 200;
  localparam int          MIN_RUN_DEF    = 10;
  localparam int          RESET_HOLD_DEF = 3;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Loader stream and data-memory write port as seen by the run controller.
interface cpu_run_ctrl_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;

  // master: loader source and memory sink; slave: the controller
  modport master (
    output ld_valid, ld_addr, ld_data, ld_last,
    input  ld_ready, dmem_we, dmem_addr, dmem_wdata
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_last,
    output ld_ready, dmem_we, dmem_addr, dmem_wdata
  );
endinterface

// File: rtl/cpu_run_ctrl_dmem_port_mux.sv
// Combinational data-memory write-port owner select with misaligned-beat write gate.
module dmem_port_mux
  import cpu_run_pkg::*;
(
  input  dmem_owner_e owner,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        ld_misaligned
);

  assign ld_misaligned = !word_aligned(ld_addr);

  always_comb begin
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    case (owner)
      OWN_LOADER: begin
        dmem_we    = ld_valid && !ld_misaligned;
        dmem_addr  = ld_addr;
        dmem_wdata = ld_data;
      end
      OWN_CPU: begin
        dmem_we    = cpu_we;
        dmem_addr  = cpu_addr;
        dmem_wdata = cpu_wdata;
      end
      OWN_CPU_RO: begin
        dmem_addr  = cpu_addr;
        dmem_wdata = cpu_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: holds the CPU in reset, preloads data memory from the loader,
// then runs the CPU until the halt PC is reached or the cycle budget expires.
//   state   | meaning
//   IDLE    | CPU in reset, waiting for start
//   HOLD    | CPU in reset for RESET_HOLD cycles, flags cleared
//   LOAD    | loader owns the memory port until the last beat
//   RUN     | CPU released, counting cycles, watching the PC
//   DONE    | halt PC reached, memory write-protected
//   TIMEOUT | cycle budget exhausted, memory write-protected
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter logic [31:0] HALT_PC    = HALT_PC_DEF,
  parameter int          MIN_RUN    = MIN_RUN_DEF,
  parameter int          MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int          RESET_HOLD = RESET_HOLD_DEF,
  parameter int          CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  cpu_run_ctrl_if.slave     mem,
  output logic              cpu_reset,
  input  logic [31:0]       cpu_pc,
  input  logic              cpu_dmem_we,
  input  logic [31:0]       cpu_dmem_addr,
  input  logic [31:0]       cpu_dmem_wdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              addr_err,
  output logic [CNT_W-1:0]  run_cycles
);

  localparam int HW = $clog2(RESET_HOLD + 1);

  run_state_e  state_q, state_d;
  logic [HW-1:0] hold_q;
  dmem_owner_e owner;
  logic        beat_acc, halt_hit, budget_hit, ld_misaligned;

  assign beat_acc   = (state_q == ST_LOAD) && mem.ld_valid;
  assign halt_hit   = (cpu_pc == HALT_PC) && (run_cycles >= CNT_W'(MIN_RUN));
  assign budget_hit = run_cycles == CNT_W'(MAX_CYCLES - 1);
  assign busy       = (state_q == ST_HOLD) || (state_q == ST_LOAD) || (state_q == ST_RUN);

  always_comb begin
    state_d      = state_q;
    owner        = OWN_NONE;
    cpu_reset    = 1'b1;
    mem.ld_ready = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_HOLD;
      ST_HOLD: if (hold_q == '0) state_d = ST_LOAD;
      ST_LOAD: begin
        mem.ld_ready = 1'b1;
        owner        = OWN_LOADER;
        if (beat_acc && mem.ld_last) state_d = ST_RUN;
      end
      ST_RUN: begin
        cpu_reset = 1'b0;
        owner     = OWN_CPU;
        // halt has priority when both land on the same cycle
        if (halt_hit)        state_d = ST_DONE;
        else if (budget_hit) state_d = ST_TIMEOUT;
      end
      ST_DONE, ST_TIMEOUT: begin
        cpu_reset = 1'b0;
        owner     = OWN_CPU_RO;
        if (start) state_d = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      run_cycles <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_HOLD && state_q != ST_HOLD) begin
        hold_q     <= HW'(RESET_HOLD - 1);
        run_cycles <= '0;
        done       <= 1'b0;
        timeout    <= 1'b0;
        addr_err   <= 1'b0;
      end else if (state_q == ST_HOLD) begin
        hold_q <= hold_q - 1'b1;
      end
      if (state_q == ST_RUN) begin
        if (run_cycles != '1) run_cycles <= run_cycles + 1'b1;
        if (state_d == ST_DONE)    done    <= 1'b1;
        if (state_d == ST_TIMEOUT) timeout <= 1'b1;
      end
      if (beat_acc && ld_misaligned) addr_err <= 1'b1;
    end
  end

  dmem_port_mux u_mux (
    .owner         (owner),
    .ld_valid      (mem.ld_valid),
    .ld_addr       (mem.ld_addr),
    .ld_data       (mem.ld_data),
    .cpu_we        (cpu_dmem_we),
    .cpu_addr      (cpu_dmem_addr),
    .cpu_wdata     (cpu_dmem_wdata),
    .dmem_we       (mem.dmem_we),
    .dmem_addr     (mem.dmem_addr),
    .dmem_wdata    (mem.dmem_wdata),
    .ld_misaligned (ld_misaligned)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized bench for cpu_run_ctrl; expectations derive from sequence timing rules.
module tb_cpu_run_ctrl;
  import cpu_run_pkg::*;

  localparam int          MIN_RUN = 10;
  localparam int          MAX_CYC = 200;
  localparam int          HOLD    = 3;
  localparam int          CNT_W   = 16;
  localparam logic [31:0] HALT    = 32'h38;

  logic clk = 1'b0;
  logic reset, start, cpu_reset, cpu_dmem_we;
  logic [31:0] cpu_pc, cpu_dmem_addr, cpu_dmem_wdata;
  logic busy, done, timeout, addr_err;
  logic [CNT_W-1:0] run_cycles;

  cpu_run_ctrl_if bus ();

  cpu_run_ctrl #(
    .HALT_PC(HALT), .MIN_RUN(MIN_RUN), .MAX_CYCLES(MAX_CYC),
    .RESET_HOLD(HOLD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mem(bus),
    .cpu_reset(cpu_reset), .cpu_pc(cpu_pc), .cpu_dmem_we(cpu_dmem_we),
    .cpu_dmem_addr(cpu_dmem_addr), .cpu_dmem_wdata(cpu_dmem_wdata),
    .busy(busy), .done(done), .timeout(timeout), .addr_err(addr_err),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] beat_addr[$];
  logic [31:0] beat_data[$];
  logic [31:0] mem_img [0:63];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = $urandom & 32'hFFFF_FFFC;
    if (p == HALT) p = p + 32'd4;
    return p;
  endfunction

  task automatic rand_cpu();
    cpu_pc         = rand_pc();
    cpu_dmem_we    = 1'($urandom_range(0, 1));
    cpu_dmem_addr  = $urandom;
    cpu_dmem_wdata = $urandom;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cpu_reset"}, cpu_reset, 1'b1);
    check({tag, "_ld_ready"}, bus.ld_ready, 1'b0);
    check({tag, "_dmem_we"}, bus.dmem_we, 1'b0);
    check({tag, "_dmem_addr"}, bus.dmem_addr, 32'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_flags"}, {done, timeout, addr_err}, 3'b000);
    check({tag, "_run_cycles"}, run_cycles, 0);
  endtask

  // halt_at < 0: never hit HALT after the early probe; abort_* < 0: no mid-sequence reset
  task automatic run_seq(input string tag, input int halt_at, input int gap_pct,
                         input int abort_beat, input int abort_run);
    int  b, k, cyc;
    bit  fin, exp_done, exp_to, exp_err, valid;
    next_cycle();
    start = 1'b1;
    rand_cpu();
    bus.ld_valid = 1'b1;
    settle();
    for (int i = 0; i < HOLD; i++) begin
      next_cycle();
      start = 1'($urandom_range(0, 1));
      bus.ld_valid = 1'($urandom_range(0, 1));
      rand_cpu();
      cpu_dmem_we = 1'b1;
      settle();
      check({tag, "_hold_busy"}, busy, 1'b1);
      check({tag, "_hold_ctl"}, {cpu_reset, bus.ld_ready, bus.dmem_we}, 3'b100);
      if (i == 0)
        check({tag, "_hold_clr"}, {done, timeout, addr_err, run_cycles}, '0);
    end
    b = 0; cyc = 0; exp_err = 0;
    while (b < beat_addr.size()) begin
      next_cycle();
      start = 1'b0;
      rand_cpu();
      cyc++;
      if (cyc > 500) begin
        check({tag, "_load_bound"}, 1, 0);
        return;
      end
      valid = ($urandom_range(0, 99) >= gap_pct);
      bus.ld_valid = valid;
      bus.ld_addr  = valid ? beat_addr[b] : $urandom;
      bus.ld_data  = valid ? beat_data[b] : $urandom;
      bus.ld_last  = valid ? (b == beat_addr.size() - 1) : 1'($urandom_range(0, 1));
      settle();
      check({tag, "_load_ctl"}, {cpu_reset, bus.ld_ready}, 2'b11);
      check({tag, "_load_err"}, addr_err, exp_err);
      check({tag, "_load_we"}, bus.dmem_we, valid && (bus.ld_addr[1:0] == 2'b00));
      check({tag, "_load_port"}, {bus.dmem_addr, bus.dmem_wdata}, {bus.ld_addr, bus.ld_data});
      if (bus.dmem_we) mem_img[bus.dmem_addr[7:2]] = bus.dmem_wdata;
      if (valid) begin
        if (bus.ld_addr[1:0] != 2'b00) exp_err = 1;
        if (b == abort_beat) begin
          reset = 1'b1;
          next_cycle();
          reset = 1'b0;
          bus.ld_valid = 1'b1;
          cpu_dmem_we  = 1'b1;
          settle();
          check_idle({tag, "_abort_load"});
          bus.ld_valid = 1'b0;
          return;
        end
        b++;
      end
    end
    k = 0; fin = 0; exp_done = 0; exp_to = 0;
    while (!fin) begin
      next_cycle();
      rand_cpu();
      if (k == halt_at || k == 5) cpu_pc = HALT;
      bus.ld_valid = 1'($urandom_range(0, 1));
      bus.ld_addr  = $urandom;
      settle();
      check({tag, "_run_ctl"}, {cpu_reset, bus.ld_ready, busy}, 3'b001);
      check({tag, "_run_cnt"}, run_cycles, k);
      check({tag, "_run_port"}, {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata},
            {cpu_dmem_we, cpu_dmem_addr, cpu_dmem_wdata});
      if (k == abort_run) begin
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        bus.ld_valid = 1'b1;
        cpu_dmem_we  = 1'b1;
        settle();
        check_idle({tag, "_abort_run"});
        bus.ld_valid = 1'b0;
        return;
      end
      if (cpu_pc == HALT && k >= MIN_RUN) begin
        exp_done = 1; fin = 1;
      end else if (k == MAX_CYC - 1) begin
        exp_to = 1; fin = 1;
      end
      k++;
    end
    for (int j = 0; j < 3; j++) begin
      next_cycle();
      start = 1'b0;
      rand_cpu();
      cpu_dmem_we = 1'b1;
      bus.ld_valid = 1'b0;
      settle();
      check({tag, "_end_flags"}, {done, timeout, addr_err}, {exp_done, exp_to, exp_err});
      check({tag, "_end_cnt"}, run_cycles, k);
      check({tag, "_end_ctl"}, {cpu_reset, busy, bus.dmem_we}, 3'b000);
      check({tag, "_end_addr"}, bus.dmem_addr, cpu_dmem_addr);
    end
  endtask

  task automatic load_dot();
    beat_addr.delete(); beat_data.delete();
    for (int i = 0; i < 8; i++) begin
      beat_addr.push_back(32'(i * 4));
      beat_data.push_back(32'(i + 1 + (i >= 4 ? 0 : 0)));
    end
    for (int i = 0; i < 64; i++) mem_img[i] = '0;
  endtask

  task automatic check_dot(input string tag);
    logic [31:0] s;
    s = 0;
    for (int i = 0; i < 4; i++) s = s + mem_img[i] * mem_img[4 + i];
    check(tag, s, 32'd70);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_last = 1'b0;
    cpu_pc = '0; cpu_dmem_we = 1'b0; cpu_dmem_addr = '0; cpu_dmem_wdata = '0;
    next_cycle();
    next_cycle();
    settle();
    check_idle("reset");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 32'h10;
      rand_cpu();
      cpu_dmem_we = 1'b1;
      settle();
      check_idle("idle");
    end
    bus.ld_valid = 1'b0;

    // A=[1,2,3,4] at 0..12, B=[5,6,7,8] at 16..28
    load_dot();
    run_seq("dot", $urandom_range(MIN_RUN + 1, 150), 0, -1, -1);
    check_dot("dot_sum");

    beat_addr.delete(); beat_data.delete();
    for (int i = 0; i < 6; i++) begin
      beat_addr.push_back({24'h0, 6'($urandom_range(0, 63)), 2'b00});
      beat_data.push_back($urandom);
    end
    run_seq("bp", MIN_RUN, 40, -1, -1);
    run_seq("tmo", -1, 20, -1, -1);
    run_seq("tie", MAX_CYC - 1, 10, -1, -1);

    beat_addr.delete(); beat_data.delete();
    beat_addr.push_back(32'h0); beat_addr.push_back(32'h6); beat_addr.push_back(32'h8);
    for (int i = 0; i < 3; i++) beat_data.push_back($urandom);
    run_seq("mis", 20, 0, -1, -1);

    load_dot();
    run_seq("abl", 30, 30, 2, -1);
    load_dot();
    run_seq("rerun1", 40, 0, -1, -1);
    check_dot("rerun1_sum");
    run_seq("abr", 60, 0, -1, 30);
    load_dot();
    run_seq("rerun2", 12, 0, -1, -1);
    check_dot("rerun2_sum");

    for (int r = 0; r < 4; r++) begin
      beat_addr.delete(); beat_data.delete();
      for (int i = 0; i < $urandom_range(1, 8); i++) begin
        beat_addr.push_back({24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))});
        beat_data.push_back($urandom);
      end
      run_seq("rnd", ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, MAX_CYC - 1)),
              $urandom_range(0, 50), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
